excp_vector_unit: RTL
=====================

// Module: excp_vector_unit
// PURPOSE
//  Exception sequencer feeding the PC source mux. On a raised exception it saves EPC,
//  reads the handler-address byte from the cause's vector location in memory, and
//  presents it as the 32-bit exception code on the mux's input 5.
//  It then issues a one-cycle PC write with PC source 5.
//  Sits between the control unit, the ALU/divider flags, memory and the PC source mux.
// PARAMETERS
//  MEM_LAT     2    memory read latency in cycles (address stable -> data valid); >= 1
//  VEC_OPCODE  253  vector byte address, invalid opcode
//  VEC_OVF     254  vector byte address, arithmetic overflow
//  VEC_DIV0    255  vector byte address, divide by zero
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   synchronous, active-high reset
//  excp_opcode  in   1   invalid-opcode exception request
//  excp_ovf     in   1   overflow exception request
//  excp_div0    in   1   divide-by-zero exception request
//  pc_in        in   32  current PC (already incremented by 4)
//  mem_data_in  in   32  memory read data; bits [7:0] hold the addressed byte
//  mem_addr     out  32  memory address driven while reading the vector
//  mem_read     out  1   memory read strobe
//  epc_out      out  32  saved EPC value
//  epc_write    out  1   EPC register load strobe, one cycle
//  excp_code    out  32  handler address (to PC source mux input 5)
//  pc_src       out  3   PC source select request (5 while jumping, else 0)
//  pc_write     out  1   PC write strobe, one cycle
//  excp_cause   out  2   latched cause: 0 none, 1 opcode, 2 ovf, 3 div0
//  busy         out  1   high whenever state != IDLE
// BEHAVIOUR
//  - All outputs registered (Moore). Reset: state IDLE, counter 0, every output 0.
//  - Reset wins over every event, including mid-sequence; no strobe fires after it.
//  - States: IDLE -> READ -> JUMP -> IDLE.
//  - IDLE: on an edge with any excp_* high:
//     - latch cause (priority opcode > ovf > div0);
//     - epc_out <= pc_in - 32'd4 (mod 2^32);
//     - counter <= MEM_LAT-1; go to READ.
//  - READ (exactly MEM_LAT cycles):
//     - mem_read=1 and mem_addr=zext(vector of cause), both stable throughout;
//     - epc_write=1 in the first READ cycle only;
//     - counter decrements each edge; on the edge with counter==0,
//       excp_code <= {24'b0, mem_data_in[7:0]} and go to JUMP.
//  - JUMP (1 cycle): pc_write=1, pc_src=3'd5, mem_read=0; then IDLE.
//  - Leaving JUMP: pc_src returns to 0 and excp_cause clears to 0.
//  - Latency: trigger sampled at edge 0; pc_write high in cycle MEM_LAT+1.
//  - excp_code and epc_out hold until the next exception or reset.
//  - excp_* while busy is ignored; it is neither queued nor allowed to alter the cause.
//  - Requests are level; one still high on the edge that enters IDLE is sampled on the
//    following edge and starts a new sequence.
// TESTING (MEM_LAT=2)
//  - reset 2 cycles -> all outputs 0, busy 0.
//  - excp_ovf pulse, pc_in=0x0000_0104, byte[254]=0x40 ->
//    epc_out=0x100; epc_write in cycle 1; mem_addr=254 in cycles 1-2;
//    excp_code=0x40; pc_write=1 and pc_src=5 in cycle 3 only.
//  - excp_opcode+excp_div0 same edge -> cause=1, mem_addr=253.
//  - excp_div0 raised during READ -> ignored; one pc_write; cause stays as latched.
//  - reset asserted in READ -> next cycle IDLE; no pc_write; excp_code=0.
//  - pc_in=0x0000_0000 -> epc_out=0xFFFF_FFFC; byte 0xFF -> excp_code=0x0000_00FF.

Source files
------------

// File: rtl/excp_vector_unit_if.sv
// Signal bundle between the exception sequencer and the control unit, memory and PC mux.
// The slave modport is the sequencer's view; master is the surrounding datapath's view.
interface excp_vector_unit_if;
  logic        excp_opcode;
  logic        excp_ovf;
  logic        excp_div0;
  logic [31:0] pc_in;
  logic [31:0] mem_data_in;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic [31:0] epc_out;
  logic        epc_write;
  logic [31:0] excp_code;
  logic [2:0]  pc_src;
  logic        pc_write;
  logic [1:0]  excp_cause;
  logic        busy;

  modport slave (
    input  excp_opcode, excp_ovf, excp_div0, pc_in, mem_data_in,
    output mem_addr, mem_read, epc_out, epc_write, excp_code,
           pc_src, pc_write, excp_cause, busy
  );

  modport master (
    output excp_opcode, excp_ovf, excp_div0, pc_in, mem_data_in,
    input  mem_addr, mem_read, epc_out, epc_write, excp_code,
           pc_src, pc_write, excp_cause, busy
  );
endinterface

// File: rtl/excp_vector_unit.sv
// Exception sequencer: saves EPC, fetches the handler byte from the cause's vector
// location, then requests a one-cycle PC write from PC-mux input 5. All outputs registered.
module excp_vector_unit #(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned VEC_OPCODE = 253,
  parameter int unsigned VEC_OVF    = 254,
  parameter int unsigned VEC_DIV0   = 255
) (
  input logic               clk,
  input logic               reset,
  excp_vector_unit_if.slave bus
);

  localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_JUMP
  } state_t;

  typedef enum logic [1:0] {
    C_NONE   = 2'd0,
    C_OPCODE = 2'd1,
    C_OVF    = 2'd2,
    C_DIV0   = 2'd3
  } cause_t;

  state_t      r_state,    w_state;
  logic [CW-1:0] r_cnt,    w_cnt;
  logic [31:0] r_mem_addr, w_mem_addr;
  logic        r_mem_read, w_mem_read;
  logic [31:0] r_epc,      w_epc;
  logic        r_epc_write, w_epc_write;
  logic [31:0] r_code,     w_code;
  logic [2:0]  r_pc_src,   w_pc_src;
  logic        r_pc_write, w_pc_write;
  cause_t      r_cause,    w_cause;
  logic        r_busy,     w_busy;

  cause_t      w_req_cause;
  logic        w_req_any;
  logic        w_unused_data;

  function automatic logic [31:0] vec_addr(input cause_t c);
    case (c)
      C_OPCODE: vec_addr = 32'(VEC_OPCODE);
      C_OVF:    vec_addr = 32'(VEC_OVF);
      C_DIV0:   vec_addr = 32'(VEC_DIV0);
      default:  vec_addr = '0;
    endcase
  endfunction

  // Fixed priority: opcode > ovf > div0.
  always_comb begin
    w_req_any   = bus.excp_opcode | bus.excp_ovf | bus.excp_div0;
    w_req_cause = C_NONE;
    if (bus.excp_opcode)    w_req_cause = C_OPCODE;
    else if (bus.excp_ovf)  w_req_cause = C_OVF;
    else if (bus.excp_div0) w_req_cause = C_DIV0;
  end

  assign w_unused_data = ^bus.mem_data_in[31:8];

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_mem_addr  = r_mem_addr;
    w_mem_read  = r_mem_read;
    w_epc       = r_epc;
    w_epc_write = 1'b0;
    w_code      = r_code;
    w_pc_src    = r_pc_src;
    w_pc_write  = 1'b0;
    w_cause     = r_cause;
    w_busy      = r_busy;

    case (r_state)
      S_IDLE: begin
        if (w_req_any) begin
          w_state     = S_READ;
          w_cause     = w_req_cause;
          w_epc       = bus.pc_in - 32'd4;
          w_cnt       = CW'(MEM_LAT - 1);
          w_mem_read  = 1'b1;
          w_mem_addr  = vec_addr(w_req_cause);
          w_epc_write = 1'b1;
          w_busy      = 1'b1;
        end
      end
      S_READ: begin
        // Outputs are registered, so the JUMP-cycle strobes are set on the last READ edge.
        if (r_cnt == '0) begin
          w_state    = S_JUMP;
          w_code     = {24'b0, bus.mem_data_in[7:0]};
          w_mem_read = 1'b0;
          w_mem_addr = '0;
          w_pc_write = 1'b1;
          w_pc_src   = 3'd5;
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end
      S_JUMP: begin
        w_state  = S_IDLE;
        w_pc_src = '0;
        w_cause  = C_NONE;
        w_busy   = 1'b0;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_mem_addr  <= '0;
      r_mem_read  <= 1'b0;
      r_epc       <= '0;
      r_epc_write <= 1'b0;
      r_code      <= '0;
      r_pc_src    <= '0;
      r_pc_write  <= 1'b0;
      r_cause     <= C_NONE;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_mem_addr  <= w_mem_addr;
      r_mem_read  <= w_mem_read;
      r_epc       <= w_epc;
      r_epc_write <= w_epc_write;
      r_code      <= w_code;
      r_pc_src    <= w_pc_src;
      r_pc_write  <= w_pc_write;
      r_cause     <= w_cause;
      r_busy      <= w_busy;
    end
  end

  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_read   = r_mem_read;
  assign bus.epc_out    = r_epc;
  assign bus.epc_write  = r_epc_write;
  assign bus.excp_code  = r_code;
  assign bus.pc_src     = r_pc_src;
  assign bus.pc_write   = r_pc_write;
  assign bus.excp_cause = r_cause;
  assign bus.busy       = r_busy;

endmodule
